// File: rtl/wallace_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wallace_mult_pkg
// Description : Shared types, widths and helpers for the sequenced 16x16
//               multiplier and its 8x8 Wallace core.
//               - state_t   : sequencer states IDLE / MUL / DONE
//               - beat_t    : 2-bit beat index (which byte pair is multiplied)
//               - csa_t     : sum/carry pair produced by a 3:2 compressor row
//               - csa3()    : word-level 3:2 carry-save compressor
//               - next_beat(): next required beat above the current one
// Revision    : 1.0 - initial release
// ============================================================================
package wallace_mult_pkg;

  localparam int OPW   = 16;
  localparam int PRODW = 32;
  localparam int COREW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] beat_t;

  typedef struct packed {
    logic [2*COREW-1:0] s;
    logic [2*COREW-1:0] c;
  } csa_t;

  // One row of full adders working on whole words. The carry word is moved up
  // one bit; the dropped MSB is always zero because the core product fits in
  // 2*COREW bits.
  function automatic csa_t csa3(input logic [2*COREW-1:0] x,
                                input logic [2*COREW-1:0] y,
                                input logic [2*COREW-1:0] z);
    csa_t               r;
    logic [2*COREW-1:0] maj;
    maj = (x & y) | (x & z) | (y & z);
    r.s = x ^ y ^ z;
    r.c = maj << 1;
    return r;
  endfunction

  // Returns {found, beat}: the smallest required beat strictly above cur.
  function automatic logic [2:0] next_beat(input logic [3:0] req, input beat_t cur);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if ((i > int'(cur)) && req[i]) begin
        r = {1'b1, 2'(i)};
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wallace_mult16_seq_ctrl_core.sv
`default_nettype none
// ============================================================================
// Module      : wallace_mult16_seq_ctrl_core
// Description : Combinational 8x8 unsigned multiplier. Eight AND-gated
//               partial-product rows are reduced by a Wallace tree of 3:2
//               compressors (8 -> 6 -> 4 -> 3 -> 2 rows) and the final
//               sum/carry pair is resolved by one carry-propagate adder.
// Ports       : a_i [7:0]  multiplicand byte
//               b_i [7:0]  multiplier byte
//               p_o [15:0] a_i * b_i
// Revision    : 1.0 - initial release
// ============================================================================
module wallace_mult16_seq_ctrl_core
  import wallace_mult_pkg::*;
(
  input  logic [COREW-1:0]   a_i,
  input  logic [COREW-1:0]   b_i,
  output logic [2*COREW-1:0] p_o
);

  logic [2*COREW-1:0] w_pp [COREW];

  for (genvar i = 0; i < COREW; i++) begin : g_pp
    assign w_pp[i] = {{COREW{1'b0}}, (a_i & {COREW{b_i[i]}})} << i;
  end

  csa_t w_l1a, w_l1b, w_l2a, w_l2b, w_l3, w_l4;

  // Level 1: 8 rows -> 6
  assign w_l1a = csa3(w_pp[0], w_pp[1], w_pp[2]);
  assign w_l1b = csa3(w_pp[3], w_pp[4], w_pp[5]);
  // Level 2: 6 rows -> 4
  assign w_l2a = csa3(w_l1a.s, w_l1a.c, w_l1b.s);
  assign w_l2b = csa3(w_l1b.c, w_pp[6], w_pp[7]);
  // Level 3: 4 rows -> 3
  assign w_l3  = csa3(w_l2a.s, w_l2a.c, w_l2b.s);
  // Level 4: 3 rows -> 2
  assign w_l4  = csa3(w_l3.s, w_l3.c, w_l2b.c);

  assign p_o = w_l4.s + w_l4.c;

endmodule
`default_nettype wire

// File: rtl/wallace_mult16_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wallace_mult16_seq_ctrl
// Description : 16x16 unsigned multiplier built by time-multiplexing one 8x8
//               Wallace core over up to four beats, accumulating the shifted
//               partial products into a 32-bit register.
// Parameters  : TAG_W     - width of the opaque tag carried with a request
//               SKIP_ZERO - skip beats whose partial product is provably zero
// Ports       : clk, rst (async, active-high)
//               in_valid/in_ready, in_a, in_b, in_tag   - request side
//               out_valid/out_ready, out_product, out_tag - result side
//               busy - high whenever the sequencer is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module wallace_mult16_seq_ctrl
  import wallace_mult_pkg::*;
#(
  parameter int unsigned TAG_W     = 4,
  parameter bit          SKIP_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_a,
  input  logic [OPW-1:0]   in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PRODW-1:0] out_product,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  state_t           state_q, state_d;
  beat_t            beat_q,  beat_d;
  logic [OPW-1:0]   a_q,     a_d;
  logic [OPW-1:0]   b_q,     b_d;
  logic [TAG_W-1:0] tag_q,   tag_d;
  logic [PRODW-1:0] acc_q,   acc_d;

  logic               w_a_hi_nz;
  logic               w_b_hi_nz;
  logic [3:0]         w_req;
  logic [2:0]         w_next;
  logic [COREW-1:0]   w_core_a;
  logic [COREW-1:0]   w_core_b;
  logic [2*COREW-1:0] w_core_p;
  logic [PRODW-1:0]   w_pp_shifted;

  // Beat k needs a byte k[0] and b byte k[1]; a zero high byte makes every
  // beat that uses it contribute nothing.
  assign w_a_hi_nz = |a_q[OPW-1:COREW];
  assign w_b_hi_nz = |b_q[OPW-1:COREW];
  assign w_req     = SKIP_ZERO ? {w_a_hi_nz & w_b_hi_nz, w_b_hi_nz, w_a_hi_nz, 1'b1}
                               : 4'hF;
  assign w_next    = next_beat(w_req, beat_q);

  assign w_core_a = beat_q[0] ? a_q[OPW-1:COREW] : a_q[COREW-1:0];
  assign w_core_b = beat_q[1] ? b_q[OPW-1:COREW] : b_q[COREW-1:0];

  wallace_mult16_seq_ctrl_core u_core (
    .a_i (w_core_a),
    .b_i (w_core_b),
    .p_o (w_core_p)
  );

  always_comb begin
    w_pp_shifted = {{(PRODW-2*COREW){1'b0}}, w_core_p};
    case (beat_q)
      2'd0:    w_pp_shifted = {{(PRODW-2*COREW){1'b0}}, w_core_p};
      2'd3:    w_pp_shifted = {w_core_p, {(2*COREW){1'b0}}};
      default: w_pp_shifted = {{COREW{1'b0}}, w_core_p, {COREW{1'b0}}};
    endcase
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        // Operands are only sampled on acceptance, so garbage on in_a/in_b
        // while in_valid is low never reaches the registers.
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          tag_d   = in_tag;
          acc_d   = '0;
          beat_d  = 2'd0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = acc_q + w_pp_shifted;
        if (w_next[2]) begin
          beat_d = w_next[1:0];
        end else begin
          beat_d  = 2'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign out_product = acc_q;
  assign out_tag     = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_wallace_mult16_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_wallace_mult16_seq_ctrl
// Description : Self-checking bench. Two instances (SKIP_ZERO = 0 and 1) are
//               driven independently; expected results are queued at request
//               acceptance and a monitor compares them at the output side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wallace_mult16_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid    [2];
  logic [15:0] in_a        [2];
  logic [15:0] in_b        [2];
  logic [3:0]  in_tag      [2];
  logic        out_ready   [2];
  logic        in_ready    [2];
  logic        out_valid   [2];
  logic        busy        [2];
  logic [31:0] out_product [2];
  logic [3:0]  out_tag     [2];

  wallace_mult16_seq_ctrl #(.TAG_W(4), .SKIP_ZERO(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_tag(in_tag[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_product(out_product[0]), .out_tag(out_tag[0]), .busy(busy[0])
  );

  wallace_mult16_seq_ctrl #(.TAG_W(4), .SKIP_ZERO(1'b1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .in_tag(in_tag[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_product(out_product[1]), .out_tag(out_tag[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] p;
    logic [3:0]  tag;
    longint      due;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc   = 0;
  int     mode  [2];   // out_ready: 0 = always 1, 1 = random, 2 = held low
  bit     seen  [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Beats the specification requires for these operands.
  function automatic int exp_beats(input int d, input logic [15:0] a, input logic [15:0] b);
    bit ah, bh;
    ah = (a[15:8] != 8'h00);
    bh = (b[15:8] != 8'h00);
    if (d == 0) return 4;
    return 1 + int'(ah) + int'(bh) + int'(ah && bh);
  endfunction

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return {8'h00, 8'($urandom)};
      1:       return {8'($urandom), 8'h00};
      2:       return ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Presents a request and waits for it to be accepted; in_valid stays high
  // afterwards (with junk data) until idle_in() or the next issue().
  task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] tag);
    exp_t e;
    int   n;
    @(negedge clk);
    in_valid[d] = 1'b1;
    in_a[d]     = a;
    in_b[d]     = b;
    in_tag[d]   = tag;
    n = 0;
    while (!in_ready[d] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[d]) begin
      n_cmp++;
      n_err++;
      $display("FAIL dut%0d_accept_timeout: in_ready got 0, expected 1 within 500 cycles", d);
      in_valid[d] = 1'b0;
      return;
    end
    e.p   = 32'(a) * 32'(b);
    e.tag = tag;
    e.due = cyc + 1 + longint'(exp_beats(d, a, b));
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(posedge clk);
    #1;
    in_a[d]   = 16'($urandom);
    in_b[d]   = 16'($urandom);
    in_tag[d] = 4'($urandom);
  endtask

  task automatic idle_in(input int d);
    in_valid[d] = 1'b0;
    in_a[d]     = 16'($urandom);
    in_b[d]     = 16'($urandom);
    in_tag[d]   = 4'($urandom);
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (qsize(d) != 0 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (qsize(d) != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL dut%0d_drain_timeout: pending results got %0d, expected 0", d, qsize(d));
    end
  endtask

  task automatic mon(input int d);
    exp_t h;
    if (rst) begin
      seen[d] = 1'b0;
      return;
    end
    if (!out_valid[d]) return;
    if (qsize(d) == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL dut%0d_unexpected_output: got product 0x%08h, expected no output", d, out_product[d]);
      return;
    end
    if (d == 0) h = q0[0];
    else        h = q1[0];
    if (!seen[d]) begin
      chk($sformatf("dut%0d_latency_cycle", d), 32'(cyc), 32'(h.due));
      seen[d] = 1'b1;
    end
    if (out_ready[d]) begin
      chk($sformatf("dut%0d_product", d), out_product[d], h.p);
      chk($sformatf("dut%0d_tag", d), 32'(out_tag[d]), 32'(h.tag));
      chk($sformatf("dut%0d_busy_done", d), 32'(busy[d]), 32'd1);
      if (d == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
      seen[d] = 1'b0;
    end else begin
      chk($sformatf("dut%0d_held_product", d), out_product[d], h.p);
      chk($sformatf("dut%0d_in_ready_stalled", d), 32'(in_ready[d]), 32'd0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(0);
      mon(1);
    end
  end

  initial begin
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      for (int d = 0; d < 2; d++) begin
        if (mode[d] == 0)      out_ready[d] = 1'b1;
        else if (mode[d] == 1) out_ready[d] = 1'($urandom);
        else                   out_ready[d] = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mode[d]     = 0;
      in_valid[d] = 1'b0;
      in_a[d]     = 16'h0;
      in_b[d]     = 16'h0;
      in_tag[d]   = 4'h0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d_rst_in_ready", d), 32'(in_ready[d]), 32'd1);
      chk($sformatf("dut%0d_rst_out_valid", d), 32'(out_valid[d]), 32'd0);
      chk($sformatf("dut%0d_rst_busy", d), 32'(busy[d]), 32'd0);
      chk($sformatf("dut%0d_rst_product", d), out_product[d], 32'd0);
      chk($sformatf("dut%0d_rst_tag", d), 32'(out_tag[d]), 32'd0);
    end
    rst = 1'b0;

    // Full four-beat product with tag.
    issue(0, 16'hFFFF, 16'hFFFF, 4'h5);
    idle_in(0);
    drain(0);

    // Result held under back-pressure, then in_ready returns after handshake.
    mode[0] = 2;
    issue(0, 16'h1234, 16'h5678, 4'hA);
    idle_in(0);
    repeat (14) @(negedge clk);
    mode[0] = 0;
    drain(0);
    @(negedge clk);
    chk("dut0_in_ready_after_handshake", 32'(in_ready[0]), 32'd1);

    // Zero-skip latencies: one beat, then beats 0 and 1.
    issue(1, 16'h00C8, 16'h0003, 4'h1);
    idle_in(1);
    drain(1);
    issue(1, 16'h0100, 16'h0002, 4'h2);
    idle_in(1);
    drain(1);

    // Back-to-back requests with in_valid held high.
    for (int d = 0; d < 2; d++) begin
      issue(d, 16'h0011, 16'h0022, 4'h3);
      issue(d, 16'hABCD, 16'h0000, 4'h4);
      issue(d, 16'h8001, 16'h7FFF, 4'h6);
      idle_in(d);
      drain(d);
    end

    // Asynchronous reset in the middle of a transaction.
    issue(0, 16'hFFFF, 16'hFFFF, 4'h9);
    idle_in(0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("dut0_async_rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("dut0_async_rst_busy", 32'(busy[0]), 32'd0);
    chk("dut0_async_rst_in_ready", 32'(in_ready[0]), 32'd1);
    chk("dut0_async_rst_product", out_product[0], 32'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(0, 16'd2, 16'd3, 4'h7);
    idle_in(0);
    drain(0);

    // Random operands with random output stalls on both instances.
    mode[0] = 1;
    mode[1] = 1;
    fork
      begin
        for (int i = 0; i < 2500; i++) begin
          issue(0, rnd_op(), rnd_op(), 4'(i));
          if ($urandom_range(0, 3) == 0) idle_in(0);
        end
        idle_in(0);
      end
      begin
        for (int j = 0; j < 2500; j++) begin
          issue(1, rnd_op(), rnd_op(), 4'(j + 7));
          if ($urandom_range(0, 3) == 0) idle_in(1);
        end
        idle_in(1);
      end
    join
    mode[0] = 0;
    mode[1] = 0;
    drain(0);
    drain(1);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
